// File: rtl/tcnt_axi_regslice_pkg.sv
// Shared types and helpers for the multi-stage AXI channel register slice.
package tcnt_axi_regslice_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int unsigned MAX_STAGES = 8;

  // Width of the per-stage tap buses; kept at 1 so a single stage still has a legal port.
  function automatic int unsigned f_sv_w(input int unsigned stages);
    return (stages > 1) ? (stages - 1) : 1;
  endfunction

endpackage

// File: rtl/tcnt_axi_regslice_if.sv
// Valid/ready/payload bundle for one AXI channel; master drives valid/payload.
interface tcnt_axi_regslice_if #(
  parameter int unsigned PAYLOAD_W = 64
);
  logic                 valid;
  logic                 ready;
  logic [PAYLOAD_W-1:0] payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/tcnt_axi_regslice_stage.sv
// One two-entry skid stage: every output (valid, ready, payload) comes straight from a flop.
module tcnt_axi_regslice_stage
  import tcnt_axi_regslice_pkg::*;
#(
  parameter int unsigned PAYLOAD_W     = 64,
  parameter bit          RESET_PAYLOAD = 1'b1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_payload
);

  state_e               r_state;
  state_e               w_next;
  logic                 r_valid;
  logic                 r_ready;
  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] r_skid;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_main_from_in;
  logic                 w_main_from_skid;
  logic                 w_skid_from_in;

  assign w_in_fire  = i_valid & r_ready;
  assign w_out_fire = r_valid & i_ready;

  always_comb begin
    w_next           = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_next         = BUSY;
          w_main_from_in = 1'b1;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_from_in = 1'b1;
        end else if (w_in_fire) begin
          w_next         = FULL;
          w_skid_from_in = 1'b1;
        end else if (w_out_fire) begin
          w_next = EMPTY;
        end
      end
      FULL: begin
        // r_ready is low here, so only the drain side can move.
        if (w_out_fire) begin
          w_next           = BUSY;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next != EMPTY);
      r_ready <= (w_next != FULL);
    end
  end

  // Payload only moves on a handshake, so idle-bus X never reaches main.
  always_ff @(posedge aclk) begin
    if (areset && RESET_PAYLOAD) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_in) begin
        r_main <= i_payload;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= i_payload;
      end
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_valid;
  assign o_payload = r_main;

endmodule

// File: rtl/tcnt_axi_regslice.sv
// Cascade of STAGES skid stages on one AXI channel, with intermediate valid/ready taps.
module tcnt_axi_regslice
  import tcnt_axi_regslice_pkg::*;
#(
  parameter int unsigned PAYLOAD_W     = 64,
  parameter int unsigned STAGES        = 2,
  parameter bit          RESET_PAYLOAD = 1'b1
) (
  input  logic                            aclk,
  input  logic                            areset,
  tcnt_axi_regslice_if.slave              s,
  tcnt_axi_regslice_if.master             m,
  output logic [f_sv_w(STAGES)-1:0]       stage_valid,
  output logic [f_sv_w(STAGES)-1:0]       stage_ready
);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("tcnt_axi_regslice: STAGES must be in 1..%0d", MAX_STAGES);
  end

  // Link i sits between stage i-1 and stage i; link 0 is s, link STAGES is m.
  logic                 w_valid   [0:STAGES];
  logic                 w_ready   [0:STAGES];
  logic [PAYLOAD_W-1:0] w_payload [0:STAGES];

  assign w_valid[0]       = s.valid;
  assign w_payload[0]     = s.payload;
  assign s.ready          = w_ready[0];
  assign m.valid          = w_valid[STAGES];
  assign m.payload        = w_payload[STAGES];
  assign w_ready[STAGES]  = m.ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    tcnt_axi_regslice_stage #(
      .PAYLOAD_W     (PAYLOAD_W),
      .RESET_PAYLOAD (RESET_PAYLOAD)
    ) u_stage (
      .aclk      (aclk),
      .areset    (areset),
      .i_valid   (w_valid[gi]),
      .o_ready   (w_ready[gi]),
      .i_payload (w_payload[gi]),
      .o_valid   (w_valid[gi+1]),
      .i_ready   (w_ready[gi+1]),
      .o_payload (w_payload[gi+1])
    );
  end

  if (STAGES == 1) begin : g_no_taps
    assign stage_valid = '0;
    assign stage_ready = '0;
  end else begin : g_taps
    for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_tap
      assign stage_valid[gi] = w_valid[gi+1];
      assign stage_ready[gi] = w_ready[gi+1];
    end
  end

endmodule

// File: tb/tb_tcnt_axi_regslice.sv
// Bench for tcnt_axi_regslice: slices with 2, 3 and 1 stages against a FIFO scoreboard.
module tb_tcnt_axi_regslice;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: STAGES=2, index 1: STAGES=3, index 2: STAGES=1.
  logic        sv [3];
  logic [63:0] sp [3];
  logic        mr [3];
  logic        sr [3];
  logic        mv [3];
  logic [63:0] mp [3];
  logic [0:0]  stv2, str2, stv1, str1;
  logic [1:0]  stv3, str3;

  tcnt_axi_regslice_if #(.PAYLOAD_W(64)) if_s2 ();
  tcnt_axi_regslice_if #(.PAYLOAD_W(64)) if_m2 ();
  tcnt_axi_regslice_if #(.PAYLOAD_W(64)) if_s3 ();
  tcnt_axi_regslice_if #(.PAYLOAD_W(64)) if_m3 ();
  tcnt_axi_regslice_if #(.PAYLOAD_W(64)) if_s1 ();
  tcnt_axi_regslice_if #(.PAYLOAD_W(64)) if_m1 ();

  assign if_s2.valid = sv[0];  assign if_s2.payload = sp[0];  assign if_m2.ready = mr[0];
  assign if_s3.valid = sv[1];  assign if_s3.payload = sp[1];  assign if_m3.ready = mr[1];
  assign if_s1.valid = sv[2];  assign if_s1.payload = sp[2];  assign if_m1.ready = mr[2];
  assign sr[0] = if_s2.ready;  assign mv[0] = if_m2.valid;    assign mp[0] = if_m2.payload;
  assign sr[1] = if_s3.ready;  assign mv[1] = if_m3.valid;    assign mp[1] = if_m3.payload;
  assign sr[2] = if_s1.ready;  assign mv[2] = if_m1.valid;    assign mp[2] = if_m1.payload;

  tcnt_axi_regslice #(.PAYLOAD_W(64), .STAGES(2), .RESET_PAYLOAD(1'b1)) u_dut2 (
    .aclk(clk), .areset(rst), .s(if_s2), .m(if_m2), .stage_valid(stv2), .stage_ready(str2));
  tcnt_axi_regslice #(.PAYLOAD_W(64), .STAGES(3), .RESET_PAYLOAD(1'b1)) u_dut3 (
    .aclk(clk), .areset(rst), .s(if_s3), .m(if_m3), .stage_valid(stv3), .stage_ready(str3));
  tcnt_axi_regslice #(.PAYLOAD_W(64), .STAGES(1), .RESET_PAYLOAD(1'b1)) u_dut1 (
    .aclk(clk), .areset(rst), .s(if_s1), .m(if_m1), .stage_valid(stv1), .stage_ready(str1));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned cap(input int k);
    return (k == 0) ? 4 : (k == 1) ? 6 : 2;
  endfunction

  // Model: the slice is a lossless in-order queue of at most 2*STAGES beats that
  // holds its head steady while stalled; anything in flight is forgotten on reset.
  logic [63:0] mdl [3][0:4095];
  int unsigned wp [3];
  int unsigned rp [3];
  logic        hold [3];
  logic [63:0] hold_p [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        wp[k] = 0; rp[k] = 0; hold[k] = 1'b0;
      end else begin
        if (hold[k]) begin
          chk($sformatf("hold_valid[%0d]", k), 64'(mv[k]), 64'd1);
          chk($sformatf("hold_payload[%0d]", k), mp[k], hold_p[k]);
        end
        if (mv[k]) begin
          chk($sformatf("valid_has_beat[%0d]", k), 64'(wp[k] != rp[k]), 64'd1);
          if (mr[k] && wp[k] != rp[k]) begin
            chk($sformatf("order[%0d]", k), mp[k], mdl[k][rp[k] % 4096]);
            rp[k]++;
          end
        end
        if (sv[k] && sr[k]) begin
          mdl[k][wp[k] % 4096] = sp[k];
          wp[k]++;
        end
        chk($sformatf("occupancy[%0d]", k), 64'((wp[k] - rp[k]) <= cap(k)), 64'd1);
        hold[k]   = mv[k] && !mr[k];
        hold_p[k] = mp[k];
      end
    end
  end

  initial begin
    int sent, got, first_cyc, gap, srdrop, cyc;
    bit acc;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin sv[k] = 1'b0; sp[k] = '0; mr[k] = 1'b1; end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_s_ready[%0d]", k), 64'(sr[k]), 64'd0);
      chk($sformatf("rst_m_valid[%0d]", k), 64'(mv[k]), 64'd0);
      chk($sformatf("rst_m_payload[%0d]", k), mp[k], 64'd0);
    end
    chk("rst_taps2", {stv2, str2}, 64'd0);
    chk("rst_taps3", {stv3, str3}, 64'd0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) chk($sformatf("s_ready_up[%0d]", k), 64'(sr[k]), 64'd1);
    repeat (5) tick();

    // Single beat through STAGES=2: visible two edges after acceptance, for one cycle.
    sv[0] = 1'b1; sp[0] = 64'hA5;
    tick();
    sv[0] = 1'b0; sp[0] = '0;
    chk("t1_lat_minus1", 64'(mv[0]), 64'd0);
    chk("t1_stage0_valid", 64'(stv2), 64'd1);
    tick();
    chk("t1_m_valid", 64'(mv[0]), 64'd1);
    chk("t1_m_payload", mp[0], 64'hA5);
    tick();
    chk("t1_one_cycle", 64'(mv[0]), 64'd0);

    // 100-beat stream through STAGES=3.
    sent = 0; got = 0; first_cyc = -1; gap = 0; srdrop = 0;
    for (cyc = 0; cyc < 200 && got < 100; cyc++) begin
      sv[1] = (sent < 100); sp[1] = 64'(sent);
      if (mv[1]) begin
        if (got == 0) first_cyc = cyc;
        chk("t2_data", mp[1], 64'(got));
        got++;
      end else if (got > 0) gap++;
      if (sent > 0 && sent < 100 && !sr[1]) srdrop++;
      acc = sv[1] & sr[1];
      tick();
      if (acc) sent++;
    end
    sv[1] = 1'b0;
    chk("t2_count", 64'(got), 64'd100);
    chk("t2_latency", 64'(first_cyc), 64'd3);
    chk("t2_gaps", 64'(gap), 64'd0);
    chk("t2_sready_drop", 64'(srdrop), 64'd0);

    // Backpressure on STAGES=2: exactly four beats fit.
    mr[0] = 1'b0; sent = 0; got = 0;
    repeat (10) begin
      sv[0] = 1'b1; sp[0] = 64'h100 + 64'(sent);
      acc = sv[0] & sr[0];
      tick();
      if (acc) sent++;
    end
    chk("t3_accepted", 64'(sent), 64'd4);
    chk("t3_s_ready", 64'(sr[0]), 64'd0);
    chk("t3_head", mp[0], 64'h100);
    mr[0] = 1'b1;
    for (cyc = 0; cyc < 60 && got < 12; cyc++) begin
      sv[0] = (sent < 12); sp[0] = 64'h100 + 64'(sent);
      if (mv[0]) begin chk("t3_data", mp[0], 64'h100 + 64'(got)); got++; end
      acc = sv[0] & sr[0];
      tick();
      if (acc) sent++;
    end
    sv[0] = 1'b0;
    chk("t3_drained", 64'(got), 64'd12);

    // m_ready toggling, random s_valid, X on idle payload.
    sent = 0; got = 0;
    for (cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
      mr[0] = (cyc % 2 == 0);
      sv[0] = (sent < 1000) && ($urandom_range(0, 1) == 1);
      sp[0] = sv[0] ? {$urandom, $urandom} : 'x;
      if (mv[0] && mr[0]) got++;
      acc = sv[0] & sr[0];
      tick();
      if (acc) sent++;
    end
    sv[0] = 1'b0; sp[0] = '0; mr[0] = 1'b1;
    chk("t4_sent", 64'(sent), 64'd1000);
    chk("t4_got", 64'(got), 64'd1000);
    tick();

    // Reset with three beats in flight.
    mr[0] = 1'b0; sent = 0;
    for (cyc = 0; cyc < 20 && sent < 3; cyc++) begin
      sv[0] = 1'b1; sp[0] = 64'hD0 + 64'(sent);
      acc = sv[0] & sr[0];
      tick();
      if (acc) sent++;
    end
    sv[0] = 1'b0;
    chk("t5_in_flight", 64'(mv[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_m_valid_cleared", 64'(mv[0]), 64'd0);
    chk("t5_stage_valid_cleared", 64'(stv2), 64'd0);
    chk("t5_s_ready_low", 64'(sr[0]), 64'd0);
    tick();
    chk("t5_s_ready_back", 64'(sr[0]), 64'd1);
    mr[0] = 1'b1; sv[0] = 1'b1; sp[0] = 64'h77;
    tick();
    sv[0] = 1'b0;
    for (cyc = 0; cyc < 10 && !mv[0]; cyc++) tick();
    chk("t5_first_after_reset", mp[0], 64'h77);
    chk("t5_valid_seen", 64'(mv[0]), 64'd1);
    tick();

    // STAGES=1: latency 1, capacity 2, taps tied off.
    sv[2] = 1'b1; sp[2] = 64'h5A;
    tick();
    sv[2] = 1'b0;
    chk("t6_latency1", 64'(mv[2]), 64'd1);
    chk("t6_payload", mp[2], 64'h5A);
    tick();
    chk("t6_one_cycle", 64'(mv[2]), 64'd0);
    mr[2] = 1'b0; sent = 0; got = 0;
    repeat (6) begin
      sv[2] = 1'b1; sp[2] = 64'h200 + 64'(sent);
      acc = sv[2] & sr[2];
      tick();
      if (acc) sent++;
    end
    chk("t6_capacity", 64'(sent), 64'd2);
    chk("t6_s_ready", 64'(sr[2]), 64'd0);
    chk("t6_taps", {stv1, str1}, 64'd0);
    sv[2] = 1'b0; mr[2] = 1'b1;
    for (cyc = 0; cyc < 10 && got < 2; cyc++) begin
      if (mv[2]) begin chk("t6_data", mp[2], 64'h200 + 64'(got)); got++; end
      tick();
    end
    chk("t6_drained", 64'(got), 64'd2);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
